cp0_exc_req: RTL and testbench

//  Producer side of the CP0 exception interface: sits at the commit stage, collects
//  per-instruction exception candidates and external/timer/software interrupts,

---
 rtl/cp0_exc_req_if.sv | 48 ++++
 rtl/cp0_exc_req.sv | 156 +++++++++++++++
 tb/tb_cp0_exc_req.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_req_if.sv
// Commit-stage and CP0 status inputs plus the exception/flush request bundle.
// master: the request producer (cp0_exc_req); slave: the commit stage / CP0 side.
interface cp0_exc_req_if;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_mem_adel;
  logic        exc_mem_ades;
  logic [31:0] mem_vaddr;
  logic        commit_eret;
  logic [5:0]  ext_int;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic        cause_ti;
  logic [31:0] cp0_epc;
  logic        exception_en;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        eret_out;
  logic        busy;

  modport master (
    input  commit_valid, commit_pc, commit_bd, exc_if_adel, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_mem_adel, exc_mem_ades, mem_vaddr, commit_eret, ext_int,
           status_ie, status_exl, status_im, cause_ip_sw, cause_ti, cp0_epc,
    output exception_en, exc_epc, exc_bd, exc_code, exc_badvaddr, flush, redirect_pc,
           eret_out, busy
  );

  modport slave (
    output commit_valid, commit_pc, commit_bd, exc_if_adel, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_mem_adel, exc_mem_ades, mem_vaddr, commit_eret, ext_int,
           status_ie, status_exl, status_im, cause_ip_sw, cause_ti, cp0_epc,
    input  exception_en, exc_epc, exc_bd, exc_code, exc_badvaddr, flush, redirect_pc,
           eret_out, busy
  );
endinterface

// File: rtl/cp0_exc_req.sv
// Commit-stage exception/interrupt prioritiser driving the CP0 request bundle and flush.
// Latency: 1 cycle from commit to registered request (interrupt lines add 2 sync cycles).
// Backpressure: after any flush, new candidates are ignored for DRAIN_CYCLES cycles (busy=1).
module cp0_exc_req #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          DRAIN_CYCLES = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  cp0_exc_req_if.master io_bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t      r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [5:0]  r_sync1, r_sync2;
  logic        r_exc_en, r_flush, r_eret, r_bd;
  logic        w_exc_en, w_flush, w_eret, w_bd;
  logic [31:0] r_epc, r_bad, r_redir;
  logic [31:0] w_epc, w_bad, w_redir;
  logic [4:0]  r_code, w_code;
  logic [5:0]  w_hw_ip;
  logic        w_int_pend, w_sync_exc, w_take_exc;
  logic [4:0]  w_cand_code;
  logic [31:0] w_cand_bad;

  // Two-flop synchroniser for the asynchronous hardware interrupt lines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_bus.ext_int;
      r_sync2 <= r_sync1;
    end
  end

  // Timer interrupt shares IP[7] with the top hardware line
  assign w_hw_ip    = {r_sync2[5] | io_bus.cause_ti, r_sync2[4:0]};
  assign w_int_pend = (|({w_hw_ip, io_bus.cause_ip_sw} & io_bus.status_im)) &
                      io_bus.status_ie & ~io_bus.status_exl;
  assign w_sync_exc = io_bus.exc_if_adel | io_bus.exc_ri | io_bus.exc_ov | io_bus.exc_sys |
                      io_bus.exc_bp | io_bus.exc_mem_adel | io_bus.exc_mem_ades;
  assign w_take_exc = w_int_pend | w_sync_exc;

  // Fixed-priority ExcCode / BadVAddr selection; interrupts preempt everything
  always_comb begin
    w_cand_code = 5'd0;
    w_cand_bad  = 32'd0;
    if (w_int_pend) begin
      w_cand_code = 5'd0;
    end else if (io_bus.exc_if_adel) begin
      w_cand_code = 5'd4;
      w_cand_bad  = io_bus.commit_pc;
    end else if (io_bus.exc_ri) begin
      w_cand_code = 5'd10;
    end else if (io_bus.exc_ov) begin
      w_cand_code = 5'd12;
    end else if (io_bus.exc_sys) begin
      w_cand_code = 5'd8;
    end else if (io_bus.exc_bp) begin
      w_cand_code = 5'd9;
    end else if (io_bus.exc_mem_adel) begin
      w_cand_code = 5'd4;
      w_cand_bad  = io_bus.mem_vaddr;
    end else if (io_bus.exc_mem_ades) begin
      w_cand_code = 5'd5;
      w_cand_bad  = io_bus.mem_vaddr;
    end
  end

  // Next state and next registered outputs; pulses default low, data holds
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_exc_en    = 1'b0;
    w_flush     = 1'b0;
    w_eret      = 1'b0;
    w_bd        = r_bd;
    w_epc       = r_epc;
    w_code      = r_code;
    w_bad       = r_bad;
    w_redir     = r_redir;
    case (r_state)
      S_IDLE: begin
        if (io_bus.commit_valid && w_take_exc) begin
          w_exc_en    = 1'b1;
          w_flush     = 1'b1;
          w_redir     = EXC_VECTOR;
          w_bd        = io_bus.commit_bd;
          w_epc       = io_bus.commit_bd ? (io_bus.commit_pc - 32'd4) : io_bus.commit_pc;
          w_code      = w_cand_code;
          w_bad       = w_cand_bad;
          w_nxt_state = S_DRAIN;
          w_nxt_cnt   = CW'(DRAIN_CYCLES);
        end else if (io_bus.commit_valid && io_bus.commit_eret) begin
          w_eret      = 1'b1;
          w_flush     = 1'b1;
          w_redir     = io_bus.cp0_epc;
          w_nxt_state = S_DRAIN;
          w_nxt_cnt   = CW'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        w_nxt_cnt = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // State, drain counter and registered request outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_exc_en <= 1'b0;
      r_flush  <= 1'b0;
      r_eret   <= 1'b0;
      r_bd     <= 1'b0;
      r_epc    <= 32'd0;
      r_code   <= 5'd0;
      r_bad    <= 32'd0;
      r_redir  <= 32'd0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_exc_en <= w_exc_en;
      r_flush  <= w_flush;
      r_eret   <= w_eret;
      r_bd     <= w_bd;
      r_epc    <= w_epc;
      r_code   <= w_code;
      r_bad    <= w_bad;
      r_redir  <= w_redir;
    end
  end

  assign io_bus.exception_en = r_exc_en;
  assign io_bus.flush        = r_flush;
  assign io_bus.eret_out     = r_eret;
  assign io_bus.exc_bd       = r_bd;
  assign io_bus.exc_epc      = r_epc;
  assign io_bus.exc_code     = r_code;
  assign io_bus.exc_badvaddr = r_bad;
  assign io_bus.redirect_pc  = r_redir;
  assign io_bus.busy         = (r_state == S_DRAIN);
endmodule

// File: tb/tb_cp0_exc_req.sv
// Scoreboard bench for cp0_exc_req: stimulus pushes expected requests, a negedge
// monitor pops and compares whenever a request/flush/eret pulse is presented.
module tb_cp0_exc_req;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cp0_exc_req_if bus ();

  cp0_exc_req #(.EXC_VECTOR(32'hBFC0_0380), .DRAIN_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  typedef struct {
    int          cyc;
    logic        exc_en;
    logic        flush;
    logic        eret;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [31:0] redir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t new_e;

  // Held data-output model (data outputs keep their last exception values)
  logic        h_bd;
  logic [4:0]  h_code;
  logic [31:0] h_epc, h_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exc(input logic [4:0] code, input logic [31:0] epc,
                          input logic bd, input logic [31:0] bad, input int lat);
    new_e = '{cyc: cyc + lat, exc_en: 1'b1, flush: 1'b1, eret: 1'b0, bd: bd, code: code,
              epc: epc, bad: bad, redir: 32'hBFC0_0380};
    exp_q.push_back(new_e);
    h_bd = bd; h_code = code; h_epc = epc; h_bad = bad;
  endtask

  task automatic push_eret(input logic [31:0] target);
    new_e = '{cyc: cyc + 1, exc_en: 1'b0, flush: 1'b1, eret: 1'b1, bd: h_bd, code: h_code,
              epc: h_epc, bad: h_bad, redir: target};
    exp_q.push_back(new_e);
  endtask

  // Monitor: every presented pulse must match the oldest expected request
  always @(negedge clk) begin
    if (!rst && (bus.exception_en || bus.flush || bus.eret_out)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, bus.exception_en, bus.flush, bus.eret_out}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cycle", cyc, mon_e.cyc);
        chk("exception_en", {31'd0, bus.exception_en}, {31'd0, mon_e.exc_en});
        chk("flush", {31'd0, bus.flush}, {31'd0, mon_e.flush});
        chk("eret_out", {31'd0, bus.eret_out}, {31'd0, mon_e.eret});
        chk("exc_bd", {31'd0, bus.exc_bd}, {31'd0, mon_e.bd});
        chk("exc_code", {27'd0, bus.exc_code}, {27'd0, mon_e.code});
        chk("exc_epc", bus.exc_epc, mon_e.epc);
        chk("exc_badvaddr", bus.exc_badvaddr, mon_e.bad);
        chk("redirect_pc", bus.redirect_pc, mon_e.redir);
      end
    end
  end

  task automatic clear_cands();
    bus.commit_valid = 1'b0; bus.commit_bd = 1'b0; bus.commit_eret = 1'b0;
    bus.exc_if_adel = 1'b0; bus.exc_ri = 1'b0; bus.exc_ov = 1'b0; bus.exc_sys = 1'b0;
    bus.exc_bp = 1'b0; bus.exc_mem_adel = 1'b0; bus.exc_mem_ades = 1'b0;
  endtask

  // One committing instruction; v = {if_adel, ri, ov, sys, bp, mem_adel, mem_ades}
  task automatic commit1(input logic [31:0] pc, input logic bd, input logic [6:0] v,
                         input logic [31:0] va, input logic er);
    bus.commit_valid = 1'b1; bus.commit_pc = pc; bus.commit_bd = bd; bus.mem_vaddr = va;
    {bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys, bus.exc_bp,
     bus.exc_mem_adel, bus.exc_mem_ades} = v;
    bus.commit_eret = er;
    @(negedge clk);
    clear_cands();
  endtask

  // Called at the negedge where the request is visible: two blocked cycles, then idle
  task automatic drain_check(input string tag);
    chk({tag, "_busy0"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy1"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_cands();
    bus.commit_pc = 32'd0; bus.mem_vaddr = 32'd0; bus.ext_int = 6'd0;
    bus.status_ie = 1'b0; bus.status_exl = 1'b0; bus.status_im = 8'd0;
    bus.cause_ip_sw = 2'd0; bus.cause_ti = 1'b0; bus.cp0_epc = 32'd0;
    h_bd = 1'b0; h_code = 5'd0; h_epc = 32'd0; h_bad = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_exception_en", {31'd0, bus.exception_en}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_eret", {31'd0, bus.eret_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_epc", bus.exc_epc, 32'd0);
    chk("rst_redirect", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Overflow, not in delay slot
    push_exc(5'd12, 32'h8000_1000, 1'b0, 32'd0, 1);
    commit1(32'h8000_1000, 1'b0, 7'b0010000, 32'd0, 1'b0);
    drain_check("ov");

    // Store address error in a delay slot
    push_exc(5'd5, 32'h8000_2000, 1'b1, 32'h0000_1001, 1);
    commit1(32'h8000_2004, 1'b1, 7'b0000001, 32'h0000_1001, 1'b0);
    drain_check("ades");

    // ERET: data outputs keep the AdES values
    bus.cp0_epc = 32'hBFC0_0100;
    push_eret(32'hBFC0_0100);
    commit1(32'h8000_2100, 1'b0, 7'b0000000, 32'd0, 1'b1);
    drain_check("eret");

    // Priority vectors
    push_exc(5'd4, 32'h8000_0100, 1'b0, 32'h8000_0100, 1);
    commit1(32'h8000_0100, 1'b0, 7'b1110000, 32'd0, 1'b0);
    drain_check("ifadel");
    push_exc(5'd4, 32'h8000_0200, 1'b0, 32'h0000_2002, 1);
    commit1(32'h8000_0200, 1'b0, 7'b0000011, 32'h0000_2002, 1'b0);
    drain_check("memadel");
    push_exc(5'd8, 32'h8000_0300, 1'b0, 32'd0, 1);
    commit1(32'h8000_0300, 1'b0, 7'b0001110, 32'h0000_3000, 1'b0);
    drain_check("sys");
    push_exc(5'd9, 32'h8000_0400, 1'b0, 32'd0, 1);
    commit1(32'h8000_0400, 1'b0, 7'b0000110, 32'h0000_4000, 1'b0);
    drain_check("bp");
    // EPC wraps when a delay-slot instruction sits at address 0
    push_exc(5'd12, 32'hFFFF_FFFC, 1'b1, 32'd0, 1);
    commit1(32'h0000_0000, 1'b1, 7'b0010000, 32'd0, 1'b0);
    drain_check("wrap");

    // RI + SYS + ERET together: exception wins; BP during drain is ignored
    bus.cp0_epc = 32'hBFC0_0200;
    push_exc(5'd10, 32'h8000_6000, 1'b0, 32'd0, 1);
    commit1(32'h8000_6000, 1'b0, 7'b0101000, 32'd0, 1'b1);
    bus.commit_valid = 1'b1; bus.commit_pc = 32'h8000_6004; bus.exc_bp = 1'b1;
    chk("drain_busy0", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("drain_busy1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    clear_cands();
    chk("drain_busy_end", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);

    // Hardware interrupt line 0 through the synchroniser
    bus.status_im = 8'h04; bus.status_ie = 1'b1; bus.status_exl = 1'b0;
    bus.commit_valid = 1'b1; bus.commit_pc = 32'h8000_3000; bus.ext_int = 6'b000001;
    push_exc(5'd0, 32'h8000_3000, 1'b0, 32'd0, 3);
    repeat (3) @(negedge clk);
    clear_cands();
    bus.ext_int = 6'd0;
    drain_check("int");
    repeat (3) @(negedge clk);

    // Same interrupt with EXL set: nothing may be issued
    bus.status_exl = 1'b1; bus.ext_int = 6'b000001;
    bus.commit_valid = 1'b1; bus.commit_pc = 32'h8000_3100;
    repeat (6) @(negedge clk);
    chk("exl_no_busy", {31'd0, bus.busy}, 32'd0);
    clear_cands();
    bus.ext_int = 6'd0;
    repeat (3) @(negedge clk);
    bus.status_exl = 1'b0; bus.status_ie = 1'b0; bus.status_im = 8'd0;

    // Reset during drain, then a fresh break is issued
    push_exc(5'd12, 32'h8000_4000, 1'b0, 32'd0, 1);
    commit1(32'h8000_4000, 1'b0, 7'b0010000, 32'd0, 1'b0);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_exception_en", {31'd0, bus.exception_en}, 32'd0);
    chk("mid_rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("mid_rst_code", {27'd0, bus.exc_code}, 32'd0);
    chk("mid_rst_epc", bus.exc_epc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    h_bd = 1'b0; h_code = 5'd0; h_epc = 32'd0; h_bad = 32'd0;
    push_exc(5'd9, 32'h8000_5000, 1'b0, 32'd0, 1);
    commit1(32'h8000_5000, 1'b0, 7'b0000100, 32'd0, 1'b0);
    drain_check("post_rst_bp");

    repeat (4) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
